// File: rtl/tea_engine_param.sv
// TEA encrypt/decrypt engine: one full Feistel round per clock, valid/ready on
// both sides, mode selected per block and returned alongside the result.
module tea_engine_param #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9,
  parameter int          CNT_W  = $clog2(ROUNDS + 1)
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [31:0] in_v0,
  input  logic [31:0] in_v1,
  input  logic [31:0] key0,
  input  logic [31:0] key1,
  input  logic [31:0] key2,
  input  logic [31:0] key3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_v0,
  output logic [31:0] out_v1,
  output logic        out_mode,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Decrypt starts from the sum encrypt would have ended on.
  localparam logic [31:0]      DEC_SUM  = DELTA * 32'(ROUNDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  state_t           state_r, state_s;
  logic             accept_s, finish_s, release_s;
  logic [31:0]      v0_r, v1_r, sum_r;
  logic [31:0]      k0_r, k1_r, k2_r, k3_r;
  logic             mode_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      s_enc_s, v0n_s, v1n_s, sum_n_s;

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);

  // FSM state register
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and handshake strobes
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    finish_s  = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          finish_s = 1'b1;
          state_s  = DONE;
        end else begin
          state_s  = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // One full round; decrypt undoes the halves in reverse order with the current sum
  always_comb begin
    s_enc_s = sum_r + DELTA;
    v0n_s   = v0_r;
    v1n_s   = v1_r;
    sum_n_s = sum_r;
    if (mode_r) begin
      v1n_s   = v1_r - tea_f(v0_r, sum_r, k2_r, k3_r);
      v0n_s   = v0_r - tea_f(v1n_s, sum_r, k0_r, k1_r);
      sum_n_s = sum_r - DELTA;
    end else begin
      v0n_s   = v0_r + tea_f(v1_r, s_enc_s, k0_r, k1_r);
      v1n_s   = v1_r + tea_f(v0n_s, s_enc_s, k2_r, k3_r);
      sum_n_s = s_enc_s;
    end
  end

  // Working registers: loaded on acceptance, advanced every RUN cycle
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      v0_r   <= 32'd0;
      v1_r   <= 32'd0;
      sum_r  <= 32'd0;
      k0_r   <= 32'd0;
      k1_r   <= 32'd0;
      k2_r   <= 32'd0;
      k3_r   <= 32'd0;
      mode_r <= 1'b0;
      cnt_r  <= '0;
    end else if (accept_s) begin
      v0_r   <= in_v0;
      v1_r   <= in_v1;
      sum_r  <= in_mode ? DEC_SUM : 32'd0;
      k0_r   <= key0;
      k1_r   <= key1;
      k2_r   <= key2;
      k3_r   <= key3;
      mode_r <= in_mode;
      cnt_r  <= '0;
    end else if (state_r == RUN) begin
      v0_r   <= v0n_s;
      v1_r   <= v1n_s;
      sum_r  <= sum_n_s;
      cnt_r  <= cnt_r + CNT_W'(1);
    end else begin
      v0_r   <= v0_r;
      v1_r   <= v1_r;
      sum_r  <= sum_r;
      cnt_r  <= cnt_r;
    end
  end

  // Result registers: final round lands here directly and is held until consumed
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_v0    <= 32'd0;
      out_v1    <= 32'd0;
      out_mode  <= 1'b0;
      out_valid <= 1'b0;
    end else if (finish_s) begin
      out_v0    <= v0n_s;
      out_v1    <= v1n_s;
      out_mode  <= mode_r;
      out_valid <= 1'b1;
    end else if (release_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: doc/tea_engine_param.md
Name: tea_engine_param

Overview:
Parametrised successor of the fixed-function TEA encrypt/decrypt cores. It is a single datapath that performs either encryption or decryption, selected per block by a mode bit. It computes one full Feistel round (both half-rounds) per clock and uses a valid/ready handshake on input and output. Zero-valued data and keys are legal inputs; there is no nonzero gating. It sits behind the Wishbone register wrapper as the accelerator engine.

Parameters:
ROUNDS, 32, number of full TEA rounds (cycles); legal range 1..63.
DELTA, 32'h9E3779B9, key-schedule constant.
CNT_W, $clog2(ROUNDS+1), round counter width (derived; not overridden).

Ports:
clk  in  1  clock, rising edge
wb_rst_i  in  1  asynchronous active-high reset
in_valid  in  1  request present
in_ready  out  1  engine can accept a request (high only in IDLE)
in_mode  in  1  0 = encrypt, 1 = decrypt
in_v0  in  32  data word 0
in_v1  in  32  data word 1
key0..key3  in  32 each  128-bit key, key0 least significant
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_v0  out  32  result word 0
out_v1  out  32  result word 1
out_mode  out  1  mode of the request that produced the result
busy  out  1  high in RUN or DONE

Behaviour:
- Clock clk; reset wb_rst_i is asynchronous and active-high.
- Reset values: state = IDLE; v0, v1, sum, key registers, counter, out_v0, out_v1, out_mode = 0; out_valid = 0; busy = 0; in_ready = 1.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - On in_valid && in_ready, latch in_v0, in_v1, key0..3 and in_mode.
  - Load sum = 0 for encrypt, or sum = DELTA*ROUNDS mod 2^32 (constant) for decrypt.
  - Set the counter to 0 and go to RUN.
  - Inputs are sampled only at this acceptance edge. Later input changes have no effect.
- Round function: F(x,s,ka,kb) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb).
  - All arithmetic is mod 2^32.
  - >> is a logical shift.
- RUN, one round per clock, with s = sum+DELTA for encrypt:
  - Encrypt: v0n = v0 + F(v1,s,k0,k1); v1n = v1 + F(v0n,s,k2,k3); sum <= s.
  - Decrypt: v1n = v1 - F(v0,sum,k2,k3); v0n = v0 - F(v1n,sum,k0,k1); sum <= sum - DELTA.
  - The counter increments each RUN cycle.
- When the counter reaches ROUNDS-1 in RUN:
  - At that edge the final round result is written directly into out_v0/out_v1.
  - out_mode is set and out_valid = 1; go to DONE.
- Latency: out_valid rises exactly ROUNDS clock edges after the acceptance edge. With ROUNDS=32, that is 32 cycles.
- DONE:
  - out_valid, out_v0, out_v1 and out_mode are held stable until out_ready is sampled high.
  - On that edge, out_valid <= 0 and the FSM returns to IDLE.
  - out_v0, out_v1 and out_mode retain the last result until the next completion.
- Backpressure: out_ready low holds DONE indefinitely, with no data loss and no new acceptance.
- in_valid while busy (RUN or DONE) is ignored. The requester must hold in_valid until it sees in_ready.
- in_valid and out_ready high together in DONE: only the output handshake completes. The new request is accepted in the following IDLE cycle, so there is at least one bubble cycle.
- ROUNDS=1: RUN lasts exactly one cycle.
- Reset asserted mid-RUN or mid-DONE:
  - The engine immediately returns to reset values.
  - No partial result is exposed.
  - out_valid stays 0 until a new request completes.
- Combinational outputs: in_ready = (state==IDLE); busy = (state!=IDLE).

Test Plan:
1. Reset then idle: check in_ready=1, out_valid=0, busy=0 and outputs 0. Apply in_valid=0 for 10 cycles -> no state change.
2. Encrypt known vector, ROUNDS=32: in_v0=in_v1=0, keys all 0, mode=0 -> out_valid exactly 32 cycles after acceptance, with out_v0=32'h41EA3A0A and out_v1=32'h94BAA940.
3. Decrypt round trip: feed out_v0=32'h41EA3A0A, out_v1=32'h94BAA940, mode=1, keys 0 -> result 0/0 with out_mode=1. Repeat with 200 random data/key pairs, enc then dec -> identity each time.
4. Backpressure and input noise:
   - Hold out_ready=0 for 20 cycles after out_valid -> outputs stable and in_ready=0.
   - Toggle in_v0 and key0 during RUN -> result unchanged.
   - Raise out_ready -> IDLE next cycle.
5. Simultaneous handshake: in_valid and out_ready both high in DONE -> new request accepted one cycle later, and its result is correct.
6. Reset mid-RUN at round 10 -> all outputs 0 and in_ready=1 immediately. A new encrypt afterwards produces the known vector.
